// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and width definitions for the MiniMicro ALU.
// Also holds the common add-with-carry helper.
package alu_pkg;

    localparam int WIDTH = 32;
    localparam int OPW   = 5;

    localparam logic [OPW-1:0] OP_NOP  = 5'd0;
    localparam logic [OPW-1:0] OP_ANDS = 5'd1;
    localparam logic [OPW-1:0] OP_ORRS = 5'd2;
    localparam logic [OPW-1:0] OP_MVNS = 5'd3;
    localparam logic [OPW-1:0] OP_EORS = 5'd4;
    localparam logic [OPW-1:0] OP_ADCS = 5'd5;
    localparam logic [OPW-1:0] OP_ADDS = 5'd6;
    localparam logic [OPW-1:0] OP_SBCS = 5'd7;
    localparam logic [OPW-1:0] OP_SUB  = 5'd8;
    localparam logic [OPW-1:0] OP_MULS = 5'd9;
    localparam logic [OPW-1:0] OP_LSRS = 5'd10;
    localparam logic [OPW-1:0] OP_LSLS = 5'd11;
    localparam logic [OPW-1:0] OP_ASR  = 5'd12;
    localparam logic [OPW-1:0] OP_ROR  = 5'd13;
    localparam logic [OPW-1:0] OP_UXTB = 5'd14;
    localparam logic [OPW-1:0] OP_UXTH = 5'd15;
    localparam logic [OPW-1:0] OP_SXTB = 5'd16;
    localparam logic [OPW-1:0] OP_SXTH = 5'd17;
    localparam logic [OPW-1:0] OP_CMP  = 5'd18;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        SH_LSL,
        SH_LSR,
        SH_ASR,
        SH_ROR
    } shift_op_e;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c;
        logic             v;
    } addc_t;

    // Subtraction is done as a + ~b + cin, so this one helper yields
    // ARM-style NOT-borrow carry and signed overflow for both directions.
    function automatic addc_t add_with_carry(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             cin);
        logic [WIDTH:0] full;
        addc_t          r;
        full  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        r.sum = full[WIDTH-1:0];
        r.c   = full[WIDTH];
        r.v   = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter (LSL/LSR/ASR/ROR) with shifter carry-out.
// An amount of zero passes the operand through and keeps the incoming carry.
module alu_shifter
    import alu_pkg::*;
(
    input  shift_op_e        op,
    input  logic [WIDTH-1:0] a,
    input  logic [7:0]       n,
    input  logic             c_in,
    output logic [WIDTH-1:0] res,
    output logic             c_out
);

    localparam int SW = $clog2(WIDTH);

    logic        [WIDTH:0]     lsl_ext;
    logic        [WIDTH:0]     lsr_ext;
    logic signed [WIDTH:0]     asr_src;
    logic signed [WIDTH:0]     asr_ext;
    logic        [2*WIDTH-1:0] ror_ext;

    // A one-bit guard beside the operand catches the last bit shifted out;
    // amounts beyond the width naturally give zero (or sign fill for ASR).
    always_comb begin
        lsl_ext = {1'b0, a} << n;
        lsr_ext = {a, 1'b0} >> n;
        asr_src = {a, 1'b0};
        asr_ext = asr_src >>> n;
        ror_ext = {a, a} >> n[SW-1:0];
    end

    always_comb begin
        res   = a;
        c_out = c_in;
        if (n != 8'd0) begin
            case (op)
                SH_LSL: begin
                    res   = lsl_ext[WIDTH-1:0];
                    c_out = lsl_ext[WIDTH];
                end
                SH_LSR: begin
                    res   = lsr_ext[WIDTH:1];
                    c_out = lsr_ext[0];
                end
                SH_ASR: begin
                    res   = asr_ext[WIDTH:1];
                    c_out = asr_ext[0];
                end
                default: begin
                    res   = ror_ext[WIDTH-1:0];
                    c_out = ror_ext[WIDTH-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_core.sv
// Registered single-cycle ALU: one opcode per clock, result and NZCV flags
// captured on the rising edge.
module alu_core
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [OPW-1:0]   instruction,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH-1:0] op_res;
    logic             c_new;
    logic             v_new;
    logic             upd_nz;
    addc_t            arith;

    shift_op_e        sh_op;
    logic [WIDTH-1:0] sh_res;
    logic             sh_c;

    always_comb begin
        case (instruction)
            OP_LSLS: sh_op = SH_LSL;
            OP_LSRS: sh_op = SH_LSR;
            OP_ASR:  sh_op = SH_ASR;
            default: sh_op = SH_ROR;
        endcase
    end

    alu_shifter u_shifter (
        .op    (sh_op),
        .a     (num1),
        .n     (num2[7:0]),
        .c_in  (flags_q[FLAG_C]),
        .res   (sh_res),
        .c_out (sh_c)
    );

    always_comb begin
        result_d = result_q;
        flags_d  = flags_q;
        op_res   = '0;
        c_new    = flags_q[FLAG_C];
        v_new    = flags_q[FLAG_V];
        upd_nz   = 1'b1;
        arith    = add_with_carry(num1, num2, 1'b0);

        case (instruction)
            OP_ANDS: op_res = num1 & num2;
            OP_ORRS: op_res = num1 | num2;
            OP_MVNS: op_res = ~num1;
            OP_EORS: op_res = num1 ^ num2;
            OP_ADDS, OP_ADCS: begin
                if (instruction == OP_ADCS) begin
                    arith = add_with_carry(num1, num2, flags_q[FLAG_C]);
                end
                op_res = arith.sum;
                c_new  = arith.c;
                v_new  = arith.v;
            end
            OP_SUB, OP_CMP, OP_SBCS: begin
                arith  = add_with_carry(num1, ~num2,
                                        (instruction == OP_SBCS) ? flags_q[FLAG_C] : 1'b1);
                op_res = arith.sum;
                c_new  = arith.c;
                v_new  = arith.v;
            end
            OP_MULS: op_res = num1 * num2;
            OP_LSRS, OP_LSLS, OP_ASR, OP_ROR: begin
                op_res = sh_res;
                c_new  = sh_c;
            end
            OP_UXTB: op_res = {{(WIDTH-8){1'b0}}, num1[7:0]};
            OP_UXTH: op_res = {{(WIDTH-16){1'b0}}, num1[15:0]};
            OP_SXTB: op_res = {{(WIDTH-8){num1[7]}}, num1[7:0]};
            OP_SXTH: op_res = {{(WIDTH-16){num1[15]}}, num1[15:0]};
            default: upd_nz = 1'b0;
        endcase

        // CMP only sets flags; NOP and reserved opcodes leave everything alone.
        if (upd_nz) begin
            if (instruction != OP_CMP) begin
                result_d = op_res;
            end
            flags_d[FLAG_N] = op_res[WIDTH-1];
            flags_d[FLAG_Z] = (op_res == '0);
            flags_d[FLAG_C] = c_new;
            flags_d[FLAG_V] = v_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed scoreboard bench for alu_core: each step pushes its expected
// result/flags, then pops and compares them one cycle later.
module tb_alu_core;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  instruction;
    logic [31:0] num1;
    logic [31:0] num2;
    logic [31:0] result;
    logic [3:0]  flags;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    alu_core dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .num1        (num1),
        .num2        (num2),
        .result      (result),
        .flags       (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input logic r, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [3:0] ef,
                        input string tag);
        exp_t e;
        rst         = r;
        instruction = op;
        num1        = a;
        num2        = b;
        e.res = er;
        e.fl  = ef;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total_cnt++;
            $error("FAIL %s: scoreboard empty got %h expected entry", tag, result);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_res"}, result, e.res);
            check({e.tag, "_flg"}, {28'd0, flags}, {28'd0, e.fl});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; instruction = OP_NOP; num1 = '0; num2 = '0;
        @(negedge clk);
        // reset and logic
        step(1, OP_NOP,  32'd0,          32'd0,   32'd0,          4'b0000, "reset");
        step(0, OP_ANDS, 32'd15,         32'd10,  32'd10,         4'b0000, "ands");
        step(0, OP_ORRS, 32'd500,        32'd5,   32'd501,        4'b0000, "orrs");
        step(0, OP_MVNS, 32'hFFFFFFA0,   32'd0,   32'd95,         4'b0000, "mvns");
        step(0, OP_EORS, 32'd295,        32'd426, 32'd141,        4'b0000, "eors");
        step(0, OP_NOP,  32'd7,          32'd9,   32'd141,        4'b0000, "nop");
        // arithmetic
        step(0, OP_ADDS, 32'd9,          32'd1,   32'd10,         4'b0000, "adds");
        step(0, OP_SUB,  32'd16,         32'd4,   32'd12,         4'b0010, "sub");
        step(0, OP_ADDS, 32'h7FFFFFFF,   32'd1,   32'h80000000,   4'b1001, "adds_ovf");
        step(0, OP_ADDS, 32'hFFFFFFFF,   32'd1,   32'd0,          4'b0110, "adds_carry");
        step(0, OP_ADCS, 32'd1,          32'd1,   32'd3,          4'b0000, "adcs");
        step(0, OP_SBCS, 32'd5,          32'd2,   32'd2,          4'b0010, "sbcs");
        step(0, OP_MULS, 32'd6,          32'd7,   32'd42,         4'b0010, "muls");
        step(0, OP_MULS, 32'h00010000,   32'h00010000, 32'd0,     4'b0110, "muls_wrap");
        step(0, OP_SUB,  32'h80000000,   32'd1,   32'h7FFFFFFF,   4'b0011, "sub_ovf");
        // shifts
        step(0, OP_LSLS, 32'd13,         32'd3,   32'd104,        4'b0001, "lsls");
        step(0, OP_LSRS, 32'd13,         32'd3,   32'd1,          4'b0011, "lsrs");
        step(0, OP_ADDS, 32'd0,          32'd0,   32'd0,          4'b0100, "clr");
        step(0, OP_ASR,  32'd205,        32'd3,   32'd25,         4'b0010, "asr");
        step(0, OP_ASR,  32'h80000000,   32'd40,  32'hFFFFFFFF,   4'b1010, "asr_big");
        step(0, OP_ROR,  32'd1,          32'd1,   32'h80000000,   4'b1010, "ror");
        step(0, OP_LSLS, 32'h12345678,   32'd0,   32'h12345678,   4'b0010, "lsls0_c1");
        step(0, OP_LSLS, 32'd1,          32'd40,  32'd0,          4'b0100, "lsls_big");
        step(0, OP_LSRS, 32'h80000005,   32'd0,   32'h80000005,   4'b1000, "lsrs0_c0");
        step(0, OP_LSLS, 32'h80000001,   32'd32,  32'd0,          4'b0110, "lsls32");
        step(0, OP_ROR,  32'h000000A5,   32'd32,  32'h000000A5,   4'b0000, "ror32");
        step(0, OP_LSRS, 32'h80000000,   32'd32,  32'd0,          4'b0110, "lsrs32");
        // extends
        step(0, OP_UXTB, 32'd490,        32'd0,   32'd234,        4'b0010, "uxtb");
        step(0, OP_UXTH, 32'd56623,      32'd0,   32'd56623,      4'b0010, "uxth");
        step(0, OP_SXTB, 32'd5950485,    32'd0,   32'd21,         4'b0010, "sxtb");
        step(0, OP_SXTH, 32'd5950485,    32'd0,   32'hFFFFCC15,   4'b1010, "sxth");
        // compare
        step(0, OP_CMP,  32'd5,          32'd5,   32'hFFFFCC15,   4'b0110, "cmp_eq");
        step(0, OP_CMP,  32'd3,          32'd5,   32'hFFFFCC15,   4'b1000, "cmp_lt");
        // mid-stream reset and reserved opcodes
        step(1, OP_ADDS, 32'd1,          32'd2,   32'd0,          4'b0000, "rst_mid");
        step(0, OP_ADDS, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1010, "adds_neg");
        step(0, 5'd25,   32'd3,          32'd4,   32'hFFFFFFFE,   4'b1010, "rsvd25");
        step(0, 5'd31,   32'd0,          32'd0,   32'hFFFFFFFE,   4'b1010, "rsvd31");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 32-bit registered ALU for the MiniMicro datapath: one operation per cycle, selected by a 5-bit opcode.
- Operands are num1/num2. The result and the NZCV flags are registered on the rising clock edge.
- Sits between the register file operand buses and the write-back / condition logic.

Parameters:
- WIDTH, 32, data width (all behaviour below is specified for 32).
- OPW, 5, opcode width.

Ports:
- clk  input  1  system clock, rising edge active.
- rst  input  1  synchronous, active-high reset.
- instruction  input  5  opcode.
- num1  input  32  operand A; shift/rotate/extend source.
- num2  input  32  operand B; shift amount taken from num2[7:0].
- result  output  32  registered result.
- flags  output  4  registered {N,Z,C,V}: flags[3]=N, [2]=Z, [1]=C, [0]=V.

Behaviour:
- One clock; reset is synchronous and active-high. rst has priority: result=0 and flags=0 at the next edge.
- Latency: inputs sampled at posedge; result and flags are valid after that edge (1 cycle). Fully pipelined, no handshake.
- Opcodes:
  - 0 NOP: result and flags hold.
  - 1 ANDS: a&b.
  - 2 ORRS: a|b.
  - 3 MVNS: ~a.
  - 4 EORS: a^b.
  - 5 ADCS: a+b+C.
  - 6 ADDS: a+b.
  - 7 SBCS: a-b-(1-C).
  - 8 SUB: a-b.
  - 9 MULS: low 32 bits of a*b.
  - 10 LSRS: a>>n.
  - 11 LSLS: a<<n.
  - 12 ASR: arithmetic a>>n.
  - 13 ROR: rotate right by n mod 32.
  - 14 UXTB: zero-extend a[7:0].
  - 15 UXTH: zero-extend a[15:0].
  - 16 SXTB: sign-extend a[7:0].
  - 17 SXTH: sign-extend a[15:0].
  - 18 CMP: compute a-b for flags only; result holds.
  - 19-31 reserved: treated as NOP.
- C used by ADCS/SBCS is the registered C flag before the current edge.
- N and Z:
  - Every opcode 1-18 updates N=res[31] and Z=(res==0).
  - For CMP, res is the internal difference.
- C and V:
  - Add (ADDS/ADCS): C = carry out of bit 31; V = signed overflow.
  - Subtract (SUB/SBCS/CMP): C = NOT borrow (1 when a>=b unsigned, plus carry-in for SBCS); V = signed overflow.
  - Logic ops, MULS and extends: C and V unchanged.
  - Shifts/rotate: V unchanged.
- Shift rules, n = num2[7:0]:
  - n=0: result=a, C unchanged.
  - LSLS 1..32: C = last bit shifted out (a[32-n]). n>32: result 0, C=0.
  - LSRS 1..32: C = a[n-1]. n>32: result 0, C=0.
  - ASR n>=32: result = all copies of a[31], C=a[31].
  - ROR n!=0: C=result[31]; n a multiple of 32 leaves result=a.
- Arithmetic wraps modulo 2^32. Multiply overflow is discarded silently.

Decomposition:
- Package alu_pkg:
  - Opcode localparams (NOP..CMP, values 0-18).
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - WIDTH default.
- One sub-module, alu_shifter: combinational LSL/LSR/ASR/ROR with carry-out.
- Add/sub, logic, multiply and extends stay inline in alu_core.

Test Plan:
- Reset, logic: rst=1 for 1 cycle -> result=0, flags=0. Then:
  - ANDS 15,10 -> 10.
  - ORRS 500,5 -> 501.
  - MVNS 0xFFFFFFA0 -> 95.
  - EORS 295,426 -> 141.
  - NOP -> result and flags hold.
- Arithmetic:
  - ADDS 9,1 -> 10, flags 0000.
  - SUB 16,4 -> 12, C=1.
  - ADDS 0xFFFFFFFF,1 -> 0, Z=1, C=1.
  - ADDS 0x7FFFFFFF,1 -> 0x80000000, N=1, V=1.
  - ADCS 1,1 with C=1 -> 3.
  - MULS 6,7 -> 42.
- Shifts:
  - LSLS 13,3 -> 104.
  - LSRS 13,3 -> 1, C=1.
  - ASR 205,3 -> 25.
  - ASR 0x80000000,40 -> 0xFFFFFFFF, C=1.
  - ROR 1,1 -> 0x80000000, C=1, N=1.
  - LSLS x,0 -> x, C unchanged.
- Extends:
  - UXTB 490 -> 234.
  - UXTH 56623 -> 56623.
  - SXTB 5950485 -> 21.
  - SXTH 5950485 -> 0xFFFFCC15, N=1.
- CMP 5,5: result holds, Z=1, C=1. CMP 3,5: N=1, C=0.
- Mid-stream reset: assert rst while ADDS is presented -> next edge result=0, flags=0. Opcode 25 -> result and flags hold.
